ysyx_25040111_wb_arb: RTL and testbench
=======================================

// Module: ysyx_25040111_wb_arb
// PURPOSE
//   Write-back arbiter and scoreboard for the 16x32 register file. Shares the
//   file's single write port between EXU (src0) and LSU (src1) results.
//   Tracks registers with pending writes and flags read-after-write hazards to
//   the issue stage. Sits between EXU/LSU and the regfile write port (wen/waddr/wdata).
// PARAMETERS
//   NREG  16  number of architectural registers
//   AW    4   register address width, log2(NREG)
//   DW    32  data width
// PORTS
//   clock        in   1   rising-edge clock
//   reset_n      in   1   asynchronous reset, active low
//   issue_valid  in   1   issue stage allocates a destination register
//   issue_rd     in   AW  destination register being allocated
//   issue_ready  out  1   allocation accepted this cycle
//   chk_rs1      in   AW  source 1 of instruction in issue
//   chk_rs2      in   AW  source 2 of instruction in issue
//   hazard       out  1   a checked source has a pending write
//   s0_valid     in   1   EXU result valid
//   s0_ready     out  1   EXU result accepted
//   s0_rd        in   AW  EXU destination
//   s0_data      in   DW  EXU result
//   s1_valid     in   1   LSU result valid
//   s1_ready     out  1   LSU result accepted
//   s1_rd        in   AW  LSU destination
//   s1_data      in   DW  LSU load data
//   rf_wen       out  1   regfile write enable
//   rf_waddr     out  AW  regfile write address
//   rf_wdata     out  DW  regfile write data
//   stat_conf    out  32  count of cycles where both sources were valid
// BEHAVIOUR
//   - Reset (async, reset_n=0): busy[] all 0, rr_ptr=0 (src0 preferred),
//     rf_wen=0, rf_waddr=0, rf_wdata=0, stat_conf=0. Any in-flight grant is
//     dropped. Combinational outputs follow the cleared state.
//   - Arbitration (combinational grant): one source only -> it is granted.
//     Both valid -> source selected by rr_ptr is granted, the other sees
//     ready=0 and must hold valid/rd/data stable. sN_ready = grant to sN.
//   - rr_ptr toggles to the non-granted source on every both-valid cycle;
//     unchanged otherwise.
//   - Write port: registered, 1-cycle latency. Grant at cycle t -> rf_wen=1,
//     rf_waddr=rd, rf_wdata=data at t+1. No grant -> rf_wen=0, addr/data held.
//     Grant with rd=0 -> handshake completes, rf_wen stays 0.
//   - Scoreboard: busy[rd] set at edge when issue_valid&issue_ready&rd!=0;
//     cleared at edge of the grant cycle for that rd. busy[0] is always 0.
//   - issue_ready = !busy[issue_rd] OR (that rd is being granted this cycle).
//     WAW stall otherwise. Same-cycle clear and set of one rd: set wins, so
//     busy stays 1.
//   - hazard = (busy[chk_rs1] & chk_rs1!=0) | (busy[chk_rs2] & chk_rs2!=0),
//     evaluated on the current busy[]. At t+1 the regfile's own forwarding
//     supplies the new value, so the register is no longer a hazard.
//   - A result for a non-busy rd is written normally; busy is unaffected.
// CONFIGURATION
//   YSYX_25040111_WB_STAT_EN
//     defined: stat_conf increments (wrapping at 2^32) on every cycle where
//       s0_valid & s1_valid.
//     undefined: the counter is not built and stat_conf is tied to 0.
// TESTING
//   1. issue rd=5; s0 rd=5 data=0xDEADBEEF -> s0_ready same cycle, next cycle
//      rf_wen=1 waddr=5 wdata=0xDEADBEEF, hazard for rs1=5 drops after grant.
//   2. s0 and s1 both valid 4 cycles (rd 1/2) after reset -> grants
//      s0,s1,s0,s1; stat_conf=4 with STAT_EN, 0 without.
//   3. busy[3]=1, issue rd=3 with no write pending -> issue_ready=0; s1 grant
//      rd=3 same cycle -> issue_ready=1 and busy[3] remains 1.
//   4. s0 rd=0 data=0x1234 -> s0_ready=1, rf_wen stays 0; issue rd=0 leaves
//      busy clear, hazard=0 for chk_rs1=0.
//   5. reset_n pulsed low mid-stream with busy[7]=1 and s1 stalled -> busy
//      cleared, rf_wen=0 immediately, rr_ptr back to src0.

Source files
------------

// File: rtl/ysyx_25040111_wb_arb.sv
// ysyx_25040111_wb_arb
//   Write-back arbiter and register scoreboard for the 16x32 register file.
//   EXU (src0) and LSU (src1) results share the file's single write port.
//   A round-robin pointer settles conflicts. A busy bit per register tracks
//   pending writes. Read-after-write hazards are reported to issue, and
//   write-after-write allocations are stalled.
//
//   Optional feature macro: YSYX_25040111_WB_STAT_EN
//     defined   -> stat_conf counts cycles where both sources were valid
//     undefined -> no counter is built and stat_conf is tied to zero
module ysyx_25040111_wb_arb #(
  parameter int NREG = 16,
  parameter int AW   = 4,
  parameter int DW   = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  output logic          issue_ready,
  input  logic [AW-1:0] chk_rs1,
  input  logic [AW-1:0] chk_rs2,
  output logic          hazard,
  input  logic          s0_valid,
  output logic          s0_ready,
  input  logic [AW-1:0] s0_rd,
  input  logic [DW-1:0] s0_data,
  input  logic          s1_valid,
  output logic          s1_ready,
  input  logic [AW-1:0] s1_rd,
  input  logic [DW-1:0] s1_data,
  output logic          rf_wen,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [31:0]   stat_conf
);

  // Scoreboard and arbitration state
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            rr_ptr;      // 0: src0 wins a conflict, 1: src1 wins
  logic            rr_nxt;

  // Grant decode
  logic            both_valid;
  logic            gnt0;
  logic            gnt1;
  logic            gnt_any;
  logic [AW-1:0]   gnt_rd;
  logic [DW-1:0]   gnt_data;
  logic            issue_hit;   // issue_rd is the register being retired now

  assign both_valid = s0_valid & s1_valid;

  // Combinational grant: a lone requester wins, a conflict goes to rr_ptr
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (both_valid) begin
      if (rr_ptr == 1'b0) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = 1'b1;
      end
    end else if (s0_valid) begin
      gnt0 = 1'b1;
    end else if (s1_valid) begin
      gnt1 = 1'b1;
    end else begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  assign gnt_any  = gnt0 | gnt1;
  assign s0_ready = gnt0;
  assign s1_ready = gnt1;

  // Select the address and data of the granted source for the write port
  always_comb begin
    gnt_rd   = s0_rd;
    gnt_data = s0_data;
    if (gnt1) begin
      gnt_rd   = s1_rd;
      gnt_data = s1_data;
    end else begin
      gnt_rd   = s0_rd;
      gnt_data = s0_data;
    end
  end

  // The pointer hands priority to the loser on every conflict cycle
  always_comb begin
    rr_nxt = rr_ptr;
    if (both_valid) begin
      rr_nxt = ~rr_ptr;
    end else begin
      rr_nxt = rr_ptr;
    end
  end

  // Allocation is accepted when the register is free or is being written
  // back this very cycle. Otherwise issue stalls on the WAW dependency.
  always_comb begin
    issue_hit   = gnt_any & (gnt_rd == issue_rd);
    issue_ready = ~busy[issue_rd] | issue_hit;
  end

  // RAW hazard on current busy bits. x0 is never pending.
  always_comb begin
    hazard = (busy[chk_rs1] & (chk_rs1 != {AW{1'b0}})) |
             (busy[chk_rs2] & (chk_rs2 != {AW{1'b0}}));
  end

  // Next scoreboard: a new allocation beats a same-cycle retirement of that rd
  always_comb begin
    busy_nxt    = busy;
    busy_nxt[0] = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      if (issue_valid && issue_ready && (issue_rd == AW'(i))) begin
        busy_nxt[i] = 1'b1;
      end else if (gnt_any && (gnt_rd == AW'(i))) begin
        busy_nxt[i] = 1'b0;
      end else begin
        busy_nxt[i] = busy[i];
      end
    end
  end

  // Scoreboard and round-robin pointer registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy   <= {NREG{1'b0}};
      rr_ptr <= 1'b0;
    end else begin
      busy   <= busy_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  // Registered write port. A grant to x0 completes but never writes.
  // Address and data keep their last value while idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_wen   <= 1'b0;
      rf_waddr <= {AW{1'b0}};
      rf_wdata <= {DW{1'b0}};
    end else if (gnt_any) begin
      rf_wen   <= (gnt_rd != {AW{1'b0}});
      rf_waddr <= gnt_rd;
      rf_wdata <= gnt_data;
    end else begin
      rf_wen   <= 1'b0;
      rf_waddr <= rf_waddr;
      rf_wdata <= rf_wdata;
    end
  end

`ifdef YSYX_25040111_WB_STAT_EN
  logic [31:0] stat_cnt;

  // Conflict counter. It wraps naturally at 2^32.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_cnt <= 32'd0;
    end else if (both_valid) begin
      stat_cnt <= stat_cnt + 32'd1;
    end else begin
      stat_cnt <= stat_cnt;
    end
  end

  assign stat_conf = stat_cnt;
`else
  assign stat_conf = 32'd0;
`endif

endmodule

// File: tb/tb_ysyx_25040111_wb_arb.sv
// Self-checking bench for ysyx_25040111_wb_arb.
// A behavioural scoreboard model is compared with every output on each
// falling edge. Directed scenarios also carry hand-computed literal checks.
module tb_ysyx_25040111_wb_arb;

  localparam int AW = 4;
  localparam int DW = 32;
`ifdef YSYX_25040111_WB_STAT_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic          issue_ready;
  logic [AW-1:0] chk_rs1;
  logic [AW-1:0] chk_rs2;
  logic          hazard;
  logic          s0_valid;
  logic          s0_ready;
  logic [AW-1:0] s0_rd;
  logic [DW-1:0] s0_data;
  logic          s1_valid;
  logic          s1_ready;
  logic [AW-1:0] s1_rd;
  logic [DW-1:0] s1_data;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [31:0]   stat_conf;

  ysyx_25040111_wb_arb dut (
    .clock(clock), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard(hazard),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_rd(s0_rd), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_rd(s1_rd), .s1_data(s1_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stat_conf(stat_conf)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy [16];
  bit          m_rr;            // which source wins the next conflict
  bit          m_wen;
  logic [3:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_stat;

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_rr    = 1'b0;
    m_wen   = 1'b0;
    m_waddr = 4'd0;
    m_wdata = 32'd0;
    m_stat  = 32'd0;
  endtask

  initial model_reset();

  // Compare process: predict outputs from the model and current inputs,
  // check them, then advance the model to the state after the next edge.
  always @(negedge clock) begin
    int          winner;        // 0 none, 1 src0, 2 src1
    logic [3:0]  w_rd;
    logic [31:0] w_data;
    bit          e_iready;
    bit          e_haz;
    if (!reset_n) model_reset();
    if (s0_valid && s1_valid) winner = m_rr ? 2 : 1;
    else if (s0_valid)        winner = 1;
    else if (s1_valid)        winner = 2;
    else                      winner = 0;
    w_rd     = (winner == 2) ? s1_rd   : s0_rd;
    w_data   = (winner == 2) ? s1_data : s0_data;
    e_iready = !m_busy[issue_rd] || (winner != 0 && w_rd == issue_rd);
    e_haz    = (chk_rs1 != 4'd0 && m_busy[chk_rs1]) || (chk_rs2 != 4'd0 && m_busy[chk_rs2]);

    check("m_s0_ready",    64'(s0_ready),    64'(winner == 1));
    check("m_s1_ready",    64'(s1_ready),    64'(winner == 2));
    check("m_issue_ready", 64'(issue_ready), 64'(e_iready));
    check("m_hazard",      64'(hazard),      64'(e_haz));
    check("m_rf_wen",      64'(rf_wen),      64'(m_wen));
    check("m_rf_waddr",    64'(rf_waddr),    64'(m_waddr));
    check("m_rf_wdata",    64'(rf_wdata),    64'(m_wdata));
    check("m_stat_conf",   64'(stat_conf),   64'(m_stat));

    if (reset_n) begin
      if (winner != 0) begin
        m_busy[w_rd] = 1'b0;
        m_wen   = (w_rd != 4'd0);
        m_waddr = w_rd;
        m_wdata = w_data;
      end else begin
        m_wen = 1'b0;
      end
      if (issue_valid && e_iready && issue_rd != 4'd0) m_busy[issue_rd] = 1'b1;
      if (s0_valid && s1_valid) begin
        m_rr = !m_rr;
        if (STAT_EN) m_stat = m_stat + 32'd1;
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct packed {
    logic        iv;  logic [3:0] ird;
    logic        v0;  logic [3:0] rd0; logic [31:0] d0;
    logic        v1;  logic [3:0] rd1; logic [31:0] d1;
    logic [3:0]  rs1; logic [3:0] rs2;
  } vec_t;

  vec_t vecs [8];

  task automatic idle();
    issue_valid = 1'b0; issue_rd = 4'd0;
    chk_rs1 = 4'd0; chk_rs2 = 4'd0;
    s0_valid = 1'b0; s0_rd = 4'd0; s0_data = 32'd0;
    s1_valid = 1'b0; s1_rd = 4'd0; s1_data = 32'd0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 4'd4,  1'b1, 4'd6,  32'h60, 1'b1, 4'd4,  32'h40, 4'd3,  4'd4};
    vecs[1] = '{1'b1, 4'd4,  1'b0, 4'd0,  32'h0,  1'b1, 4'd4,  32'h41, 4'd4,  4'd6};
    vecs[2] = '{1'b1, 4'd8,  1'b1, 4'd3,  32'h30, 1'b0, 4'd0,  32'h0,  4'd8,  4'd3};
    vecs[3] = '{1'b0, 4'd0,  1'b1, 4'd8,  32'h80, 1'b1, 4'd12, 32'hC0, 4'd8,  4'd12};
    vecs[4] = '{1'b1, 4'd12, 1'b0, 4'd0,  32'h0,  1'b1, 4'd12, 32'hC1, 4'd12, 4'd0};
    vecs[5] = '{1'b1, 4'd15, 1'b1, 4'd15, 32'hF0, 1'b1, 4'd1,  32'h10, 4'd15, 4'd1};
    vecs[6] = '{1'b0, 4'd0,  1'b1, 4'd0,  32'h5,  1'b1, 4'd1,  32'h11, 4'd0,  4'd15};
    vecs[7] = '{1'b0, 4'd0,  1'b0, 4'd0,  32'h0,  1'b0, 4'd0,  32'h0,  4'd15, 4'd4};

    idle();
    reset_n = 1'b0;
    tick();
    #1;
    check("rst_rf_wen",    64'(rf_wen),    64'd0);
    check("rst_rf_waddr",  64'(rf_waddr),  64'd0);
    check("rst_rf_wdata",  64'(rf_wdata),  64'd0);
    check("rst_stat_conf", 64'(stat_conf), 64'd0);
    tick();
    reset_n = 1'b1;

    // 1: allocate r5, EXU writes it back, hazard clears after the grant
    tick();
    issue_valid = 1'b1; issue_rd = 4'd5; chk_rs1 = 4'd5;
    #1;
    check("t1_issue_ready", 64'(issue_ready), 64'd1);
    check("t1_hazard_pre",  64'(hazard),      64'd0);
    tick();
    issue_valid = 1'b0; s0_valid = 1'b1; s0_rd = 4'd5; s0_data = 32'hDEADBEEF;
    #1;
    check("t1_s0_ready",    64'(s0_ready),    64'd1);
    check("t1_hazard_busy", 64'(hazard),      64'd1);
    tick();
    idle(); chk_rs1 = 4'd5;
    #1;
    check("t1_rf_wen",   64'(rf_wen),   64'd1);
    check("t1_rf_waddr", 64'(rf_waddr), 64'd5);
    check("t1_rf_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    check("t1_hazard_post", 64'(hazard), 64'd0);

    // 2: four conflict cycles from reset alternate s0,s1,s0,s1
    pulse_reset();
    s0_valid = 1'b1; s0_rd = 4'd1; s0_data = 32'h11;
    s1_valid = 1'b1; s1_rd = 4'd2; s1_data = 32'h22;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t2_s0_ready", 64'(s0_ready), 64'((k % 2) == 0));
      check("t2_s1_ready", 64'(s1_ready), 64'((k % 2) == 1));
      tick();
    end
    idle();
    #1;
    check("t2_stat_conf", 64'(stat_conf), STAT_EN ? 64'd4 : 64'd0);
    check("t2_rf_waddr",  64'(rf_waddr),  64'd2);
    check("t2_rf_wdata",  64'(rf_wdata),  64'h22);

    // 3: WAW stall on r3, released by a same-cycle LSU write of r3
    tick();
    issue_valid = 1'b1; issue_rd = 4'd3;
    #1;
    check("t3_first_alloc", 64'(issue_ready), 64'd1);
    tick();
    #1;
    check("t3_waw_stall", 64'(issue_ready), 64'd0);
    tick();
    s1_valid = 1'b1; s1_rd = 4'd3; s1_data = 32'h33;
    #1;
    check("t3_issue_ready", 64'(issue_ready), 64'd1);
    check("t3_s1_ready",    64'(s1_ready),    64'd1);
    tick();
    idle(); chk_rs1 = 4'd3;
    #1;
    check("t3_still_busy", 64'(hazard),   64'd1);
    check("t3_rf_wen",     64'(rf_wen),   64'd1);
    check("t3_rf_wdata",   64'(rf_wdata), 64'h33);

    // 4: writes and allocations of x0 never touch the register file
    tick();
    s0_valid = 1'b1; s0_rd = 4'd0; s0_data = 32'h1234;
    issue_valid = 1'b1; issue_rd = 4'd0;
    #1;
    check("t4_s0_ready",    64'(s0_ready),    64'd1);
    check("t4_issue_ready", 64'(issue_ready), 64'd1);
    tick();
    idle();
    #1;
    check("t4_rf_wen", 64'(rf_wen), 64'd0);
    check("t4_hazard", 64'(hazard), 64'd0);

    // mixed directed vectors, checked by the model only
    for (int v = 0; v < 8; v++) begin
      tick();
      issue_valid = vecs[v].iv; issue_rd = vecs[v].ird;
      s0_valid = vecs[v].v0; s0_rd = vecs[v].rd0; s0_data = vecs[v].d0;
      s1_valid = vecs[v].v1; s1_rd = vecs[v].rd1; s1_data = vecs[v].d1;
      chk_rs1 = vecs[v].rs1; chk_rs2 = vecs[v].rs2;
    end

    // 5: reset mid-stream with r7 pending and the LSU stalled
    tick();
    idle();
    pulse_reset();
    issue_valid = 1'b1; issue_rd = 4'd7;
    s0_valid = 1'b1; s0_rd = 4'd9; s0_data = 32'h99;
    tick();
    issue_valid = 1'b0;
    s0_rd = 4'd10; s0_data = 32'hAA;
    s1_valid = 1'b1; s1_rd = 4'd7; s1_data = 32'h77;
    chk_rs1 = 4'd7;
    #1;
    check("t5_s1_stalled", 64'(s1_ready), 64'd0);
    tick();
    s0_rd = 4'd11; s0_data = 32'hBB;
    #1;
    check("t5_pre_s1_ready", 64'(s1_ready), 64'd1);
    check("t5_pre_hazard",   64'(hazard),   64'd1);
    check("t5_pre_rf_wen",   64'(rf_wen),   64'd1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_rf_wen",   64'(rf_wen),   64'd0);
    check("t5_rst_hazard",   64'(hazard),   64'd0);
    check("t5_rst_s0_ready", 64'(s0_ready), 64'd1);
    check("t5_rst_s1_ready", 64'(s1_ready), 64'd0);
    tick();
    reset_n = 1'b1;
    idle();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
